// File: rtl/simple_spi_slave.sv
// SPI mode-0 slave: synchronizes sck/cs/mosi into CLK_40, shifts bytes in and out MSB first.
// Optional macro SPI_MISO_TRISTATE_EN: miso floats while synchronized cs is high.
module simple_spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_data_strobe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_data_strobe,
  output logic              rx_start,
  output logic              rx_end_strobe
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t state, state_nxt;
  logic [1:0] settle_cnt;

  logic sck_p0, sck_p1, sck_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic mosi_p0, mosi_p1, mosi_p2;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] tx_next;

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic load_frame, end_frame, sck_en;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-2:0] acc, input logic b);
    return {acc, b};
  endfunction

  function automatic logic [CNT_W-1:0] bit_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == LAST_BIT) ? '0 : cnt + CNT_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: history flop for edge detection
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      {sck_p0, sck_p1, sck_p2}    <= 3'b000;
      {cs_p0, cs_p1, cs_p2}       <= 3'b111;
      {mosi_p0, mosi_p1, mosi_p2} <= 3'b000;
    end else begin
      {sck_p0, sck_p1, sck_p2}    <= {sck, sck_p0, sck_p1};
      {cs_p0, cs_p1, cs_p2}       <= {cs, cs_p0, cs_p1};
      {mosi_p0, mosi_p1, mosi_p2} <= {mosi, mosi_p0, mosi_p1};
    end
  end

  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign cs_fall  = ~cs_p1 & cs_p2;
  assign cs_rise  = cs_p1 & ~cs_p2;

  // mosi_p2 was captured alongside the pre-edge sck sample, so it is settled at the rising edge
  assign rx_next = shift_in(rx_shift, mosi_p2);
  assign tx_next = tx_data_strobe ? tx_data : tx_hold;

  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      state      <= ST_SETTLE;
      settle_cnt <= 2'd0;
    end else begin
      state <= state_nxt;
      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
    end
  end

  // After reset the chain must hold real pin samples and show cs idle before a frame may start
  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    end_frame  = 1'b0;
    sck_en     = 1'b0;
    case (state)
      ST_SETTLE: if (settle_cnt == 2'd3 && cs_p1 && cs_p2) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (cs_fall) begin
          load_frame = 1'b1;
          state_nxt  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (cs_rise) begin
          end_frame = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          sck_en = ~cs_p1;
        end
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  // Stage p3: shift registers, bit counter and output strobes
  always_ff @(posedge CLK_40 or negedge reset) begin
    if (!reset) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      rx_data        <= '0;
      rx_data_strobe <= 1'b0;
      rx_start       <= 1'b0;
      rx_end_strobe  <= 1'b0;
      tx_hold        <= '0;
      tx_shift       <= '0;
    end else begin
      rx_start       <= load_frame;
      rx_end_strobe  <= end_frame;
      rx_data_strobe <= 1'b0;
      if (tx_data_strobe) tx_hold <= tx_data;
      if (load_frame) begin
        bit_cnt  <= '0;
        tx_shift <= tx_next;
      end else if (end_frame) begin
        bit_cnt <= '0;
      end else if (sck_en) begin
        if (sck_rise) begin
          rx_shift <= rx_next[DATA_W-2:0];
          bit_cnt  <= bit_inc(bit_cnt);
          if (bit_cnt == LAST_BIT) begin
            rx_data        <= rx_next;
            rx_data_strobe <= 1'b1;
          end
        end else if (sck_fall) begin
          // counter wrapped to zero means the byte just finished: stream the next one
          if (bit_cnt == '0) tx_shift <= tx_next;
          else               tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

`ifdef SPI_MISO_TRISTATE_EN
  assign miso = cs_p1 ? 1'bz : tx_shift[DATA_W-1];
`else
  assign miso = tx_shift[DATA_W-1];
`endif

endmodule

// File: tb/tb_simple_spi_slave.sv
// Scoreboard bench for simple_spi_slave: SPI master stimulus, queue-based RX and MISO monitors.
module tb_simple_spi_slave;

  logic       CLK_40 = 1'b0;
  logic       reset = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_data_strobe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        miso;
  logic [7:0] rx_data;
  logic       rx_data_strobe, rx_start, rx_end_strobe;

  simple_spi_slave #(.DATA_W(8)) dut (
    .CLK_40(CLK_40), .reset(reset), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_data_strobe(rx_data_strobe), .tx_data(tx_data),
    .tx_data_strobe(tx_data_strobe), .rx_start(rx_start), .rx_end_strobe(rx_end_strobe)
  );

  always begin
    #12 CLK_40 = 1'b1;
    #13 CLK_40 = 1'b0;
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_last = 8'h00;
  int start_cnt = 0, end_cnt = 0, start_exp = 0, end_exp = 0;
  logic [7:0] mon_bits = 8'h00;
  int mon_cnt = 0;
  logic [7:0] fdata[4];
  logic [7:0] ftx[4];
  logic       fstr[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // RX monitor: every strobe must match the oldest expected byte
  always @(negedge CLK_40) begin
    if (reset) begin
      if (rx_data_strobe === 1'b1) begin
        if (exp_rx_q.size() == 0) chk("rx_strobe_unexpected", {31'b0, rx_data_strobe}, 32'd0);
        else chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx_q.pop_front()});
      end
      if (rx_start === 1'b1) start_cnt++;
      if (rx_end_strobe === 1'b1) end_cnt++;
    end
  end

  // MISO monitor: assemble what the master samples on each rising sck
  always @(posedge sck) begin
    if (cs === 1'b0) begin
      mon_bits = {mon_bits[6:0], miso};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_tx_q.size() == 0) chk("miso_expect_queue", 32'(exp_tx_q.size()), 32'd1);
        else chk("miso_byte", {24'b0, mon_bits}, {24'b0, exp_tx_q.pop_front()});
      end
    end
  end

  always @(posedge cs) mon_cnt = 0;

  task automatic wclk(input int n);
    repeat (n) @(posedge CLK_40);
    #2;
  endtask

  task automatic bit_x(input logic b);
    mosi = b;
    wclk(8);
    sck = 1'b1;
    wclk(8);
    sck = 1'b0;
  endtask

  task automatic tx_strobe(input logic [7:0] v);
    @(posedge CLK_40);
    #2;
    tx_data = v;
    tx_data_strobe = 1'b1;
    @(posedge CLK_40);
    #2;
    tx_data_strobe = 1'b0;
    m_hold = v;
  endtask

  task automatic run_frame(input int nbytes, input int tail_bits);
    int nb;
    cs = 1'b0;
    start_exp++;
    wclk(8);
    for (int k = 0; k < nbytes; k++) begin
      nb = (k == nbytes - 1 && tail_bits > 0) ? tail_bits : 8;
      if (nb == 8) begin
        exp_tx_q.push_back(m_hold);
        exp_rx_q.push_back(fdata[k]);
        m_last = fdata[k];
      end
      for (int i = 0; i < nb; i++) begin
        bit_x(fdata[k][7-i]);
        if (i == 3 && fstr[k]) tx_strobe(ftx[k]);
      end
    end
    wclk(8);
    cs = 1'b1;
    end_exp++;
    wclk(16);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_rx_start_count"}, 32'(start_cnt), 32'(start_exp));
    chk({tag, "_rx_end_count"}, 32'(end_cnt), 32'(end_exp));
    chk({tag, "_rx_data_hold"}, {24'b0, rx_data}, {24'b0, m_last});
    chk({tag, "_rx_pending"}, 32'(exp_rx_q.size()), 32'd0);
    chk({tag, "_tx_pending"}, 32'(exp_tx_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"}, {24'b0, rx_data}, 32'h0);
    chk({tag, "_rx_data_strobe"}, {31'b0, rx_data_strobe}, 32'h0);
    chk({tag, "_rx_start"}, {31'b0, rx_start}, 32'h0);
    chk({tag, "_rx_end_strobe"}, {31'b0, rx_end_strobe}, 32'h0);
`ifdef SPI_MISO_TRISTATE_EN
    chk({tag, "_miso"}, {31'b0, miso}, {31'b0, 1'bz});
`else
    chk({tag, "_miso"}, {31'b0, miso}, 32'h0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbytes, tail;
    wclk(3);
    check_reset_outputs("por");
    reset = 1'b1;
    wclk(6);

    // single byte 0xA5, holding register still zero
    fdata[0] = 8'hA5; fstr[0] = 1'b0;
    run_frame(1, 0);
    check_state("a5");

    // tx byte strobed while idle
    tx_strobe(8'h3C);
    fdata[0] = 8'($urandom); fstr[0] = 1'b0;
    run_frame(1, 0);
    check_state("tx3c");

    // back-to-back bytes with mid-byte tx strobes
    fdata[0] = 8'h01; fdata[1] = 8'h02; fdata[2] = 8'h03;
    ftx[0] = 8'h11; ftx[1] = 8'h22; ftx[2] = 8'h33;
    fstr[0] = 1'b1; fstr[1] = 1'b1; fstr[2] = 1'b1;
    run_frame(3, 0);
    check_state("b2b");

    // partial byte then full frame
    fdata[0] = 8'($urandom); fstr[0] = 1'b0;
    run_frame(1, 5);
    check_state("partial");
    fdata[0] = 8'($urandom);
    run_frame(1, 0);
    check_state("after_partial");

    // reset in the middle of a byte
    cs = 1'b0;
    start_exp++;
    wclk(8);
    for (int i = 0; i < 4; i++) bit_x(1'($urandom));
    reset = 1'b0;
    wclk(2);
    check_reset_outputs("midreset");
    cs = 1'b1;
    wclk(2);
    reset = 1'b1;
    m_hold = 8'h00;
    m_last = 8'h00;
    wclk(6);
    check_state("post_reset");
    fdata[0] = 8'($urandom); fstr[0] = 1'b0;
    run_frame(1, 0);
    check_state("reset_recover");

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 1) == 1) tx_strobe(8'($urandom));
      nbytes = $urandom_range(1, 3);
      tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 4; k++) begin
        fdata[k] = 8'($urandom);
        ftx[k] = 8'($urandom);
        fstr[k] = 1'($urandom);
      end
      run_frame(nbytes, tail);
      check_state("rand");
    end

    wclk(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
